// File: rtl/multi_pwm_gen_pkg.sv
// Shared state encoding and default sizing for the multi-channel PWM generator.
package multi_pwm_gen_pkg;

    localparam int unsigned CH_DEF    = 4;
    localparam int unsigned W_DEF     = 11;
    localparam int unsigned PRE_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/multi_pwm_gen_if.sv
// Control/status bundle of the multi-channel PWM generator.
// master = controller side (drives requests/config), slave = generator side.
interface multi_pwm_gen_if
    import multi_pwm_gen_pkg::*;
#(
    parameter int unsigned CH    = CH_DEF,
    parameter int unsigned W     = W_DEF,
    parameter int unsigned PRE_W = PRE_W_DEF
);

    logic              st;
    logic              stop;
    logic              mode;
    logic [PRE_W-1:0]  NTclk;
    logic [CH*W-1:0]   N;
    logic [CH*W-1:0]   MT;
    logic [CH*W-1:0]   PH;
    logic              ceo;
    logic [CH-1:0]     PW;
    logic [CH-1:0]     TC;
    logic [CH*W-1:0]   q;
    logic              busy;

    modport master (
        output st, stop, mode, NTclk, N, MT, PH,
        input  ceo, PW, TC, q, busy
    );

    modport slave (
        input  st, stop, mode, NTclk, N, MT, PH,
        output ceo, PW, TC, q, busy
    );

endinterface

// File: rtl/multi_pwm_gen_pwm_chan.sv
// One PWM channel: phase-loaded tick counter, width compare and period-end strobe.
// Optional feature: MULTI_PWM_GEN_SHADOW_EN holds period/width in shadow
// registers refreshed at start and at each period end of this channel.
module pwm_chan #(
    parameter int unsigned W = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    input  logic         i_run,
    input  logic         i_ceo,
    input  logic [W-1:0] i_n,
    input  logic [W-1:0] i_mt,
    input  logic [W-1:0] i_ph,
    output logic [W-1:0] o_q,
    output logic         o_pw,
    output logic         o_tc
);

    logic [W-1:0] r_q;
    logic [W-1:0] w_n;
    logic [W-1:0] w_mt;
    logic         w_en;
    logic         w_last;

`ifdef MULTI_PWM_GEN_SHADOW_EN
    logic [W-1:0] r_n_sh;
    logic [W-1:0] r_mt_sh;

    // Shadow period/width; phase is only consumed by the start load, which
    // already takes the live value being captured, so it needs no copy.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_n_sh  <= '0;
            r_mt_sh <= '0;
        end else if (i_start || o_tc) begin
            r_n_sh  <= i_n;
            r_mt_sh <= i_mt;
        end
    end

    assign w_n  = r_n_sh;
    assign w_mt = r_mt_sh;
`else
    assign w_n  = i_n;
    assign w_mt = i_mt;
`endif

    // Compare decode; >= on the wrap recovers if the period shrinks below q
    always_comb begin
        w_en   = (w_n != '0);
        w_last = w_en && (r_q >= (w_n - W'(1)));
        o_tc   = i_ceo && w_last;
        o_pw   = i_run && w_en && (r_q < w_mt);
        o_q    = r_q;
    end

    // Counter: phase load on start, advance on tick, hold otherwise
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_q <= '0;
        end else if (i_start) begin
            r_q <= (i_ph >= i_n) ? '0 : i_ph;
        end else if (i_ceo) begin
            r_q <= (w_last || !w_en) ? '0 : r_q + W'(1);
        end
    end

endmodule

// File: rtl/multi_pwm_gen.sv
// Multi-channel PWM generator: shared tick prescaler + IDLE/RUN/DONE sequencer
// driving CH pwm_chan instances. Optional feature: MULTI_PWM_GEN_SHADOW_EN
// (shadowed period/width per channel, see pwm_chan).
module multi_pwm_gen
    import multi_pwm_gen_pkg::*;
#(
    parameter int unsigned CH    = CH_DEF,
    parameter int unsigned W     = W_DEF,
    parameter int unsigned PRE_W = PRE_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    multi_pwm_gen_if.slave  bus
);

    state_t           r_state;
    state_t           w_next;
    logic [PRE_W-1:0] r_pre;
    logic             w_run;
    logic             w_start;
    logic             w_ceo;
    logic [CH-1:0]    w_pw;
    logic [CH-1:0]    w_tc;
    logic [CH*W-1:0]  w_q;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: stop beats st; st only honoured in IDLE
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (bus.st && !bus.stop) w_next = ST_RUN;
            ST_RUN: begin
                if (bus.stop)                 w_next = ST_IDLE;
                else if (bus.mode && w_tc[0]) w_next = ST_DONE;
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // State decode; tick is masked during reset so an aborted run emits no TC
    always_comb begin
        w_run   = (r_state == ST_RUN);
        w_start = (r_state == ST_IDLE) && (w_next == ST_RUN);
        w_ceo   = w_run && rst && (r_pre == bus.NTclk);
    end

    // Prescaler counts 0..NTclk while running, parked at 0 otherwise
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pre <= '0;
        end else if (w_run && (w_next == ST_RUN)) begin
            r_pre <= w_ceo ? '0 : r_pre + PRE_W'(1);
        end else begin
            r_pre <= '0;
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_chan
        pwm_chan #(.W(W)) u_chan (
            .clk     (clk),
            .rst     (rst),
            .i_start (w_start),
            .i_run   (w_run),
            .i_ceo   (w_ceo),
            .i_n     (bus.N[g*W +: W]),
            .i_mt    (bus.MT[g*W +: W]),
            .i_ph    (bus.PH[g*W +: W]),
            .o_q     (w_q[g*W +: W]),
            .o_pw    (w_pw[g]),
            .o_tc    (w_tc[g])
        );
    end

    assign bus.ceo  = w_ceo;
    assign bus.PW   = w_pw;
    assign bus.TC   = w_tc;
    assign bus.q    = w_q;
    assign bus.busy = w_run;

endmodule

// File: doc/multi_pwm_gen.md
MULTI_PWM_GEN -- requirements
Module: multi_pwm_gen

Interface
REQ-001 SHALL have parameter CH, default 4, giving the number of independent pulse channels (1..8).
REQ-002 SHALL have parameter W, default 11, giving the per-channel counter, period, width and phase width.
REQ-003 SHALL have parameter PRE_W, default 16, giving the tick-prescaler width.
REQ-004 clk  in  1  single system clock; all state changes on rising edge.
REQ-005 rst  in  1  synchronous, active-low reset.
REQ-006 st  in  1  start request, sampled each clk.
REQ-007 stop  in  1  stop request, sampled each clk.
REQ-008 mode  in  1  0 = continuous, 1 = one-shot.
REQ-009 NTclk  in  PRE_W  tick divider; one tick every NTclk+1 clk cycles.
REQ-010 N  in  CH*W  per-channel period in ticks; channel i at bits [i*W +: W].
REQ-011 MT  in  CH*W  per-channel pulse width in ticks.
REQ-012 PH  in  CH*W  per-channel phase offset in ticks.
REQ-013 ceo  out  1  single-cycle tick strobe.
REQ-014 PW  out  CH  per-channel pulse outputs.
REQ-015 TC  out  CH  per-channel single-cycle period-end strobes.
REQ-016 q  out  CH*W  per-channel counter values.
REQ-017 busy  out  1  high while the state is RUN.

Function
REQ-018 SHALL implement the states IDLE, RUN and DONE.
REQ-019 State transitions SHALL be:
- IDLE->RUN when st=1 and stop=0.
- RUN->IDLE when stop=1.
- RUN->DONE in one-shot mode on TC[0].
- DONE->IDLE unconditionally after one cycle.
REQ-020 When stop and st are both high in the same cycle, stop SHALL win.
REQ-021 st SHALL be ignored in RUN and DONE.
REQ-022 On IDLE->RUN, the prescaler SHALL clear to 0 and each q_i SHALL load PH_i, or 0 if PH_i >= N_i; the first ceo SHALL occur NTclk+1 cycles after busy rises.
REQ-023 In RUN, the prescaler SHALL count 0..NTclk; ceo SHALL be 1 for one cycle when prescaler == NTclk, and every cycle when NTclk = 0.
REQ-024 On ceo, q_i SHALL increment and wrap from N_i-1 to 0; TC_i SHALL be 1 in the cycle where ceo=1 and q_i == N_i-1.
REQ-025 PW_i SHALL equal (state == RUN) && (q_i < MT_i), decoded from registered state only.
REQ-026 Boundary rules per channel:
- MT_i = 0: PW_i constantly low.
- MT_i >= N_i: PW_i constantly high in RUN.
- N_i = 0: channel disabled; q_i held 0, PW_i and TC_i low. A disabled channel 0 in one-shot mode SHALL never reach DONE; stop is then required.
REQ-027 Outside RUN, q SHALL hold its last value, PW and TC SHALL be 0, and the prescaler SHALL hold 0.
REQ-028 Counter arithmetic SHALL be unsigned W-bit with no overflow beyond the wrap of REQ-024.

Reset
REQ-029 On clk with rst=0, the state SHALL be IDLE and ceo, PW, TC, q, busy and the prescaler SHALL all be 0, overriding st and stop.
REQ-030 Reset asserted mid-RUN SHALL abort the sequence within one cycle with no TC emitted.

Configuration
REQ-031 With MULTI_PWM_GEN_SHADOW_EN defined:
- N, MT and PH SHALL be captured into shadow registers on IDLE->RUN and on each TC_i for channel i.
- All compares SHALL use the shadow values, so input changes take effect only at the period boundary.
REQ-032 Without MULTI_PWM_GEN_SHADOW_EN, compares SHALL use N, MT and PH directly; changes SHALL take effect in the next cycle.

Structure
REQ-033 Package multi_pwm_gen_pkg SHALL hold the state encoding and the default CH, W and PRE_W constants.
REQ-034 The per-channel counter, compare and shadow logic SHALL be one sub-module pwm_chan, instantiated CH times; the prescaler and FSM SHALL be in multi_pwm_gen.

Verification
REQ-035 CH=4, NTclk=0, N0=10, MT0=3, PH0=0, continuous, st pulse -> PW[0] high 3 of every 10 cycles, TC[0] every 10th cycle, ceo every cycle.
REQ-036 NTclk=4, N1=5, MT1=2, PH1=3 -> first ceo 5 cycles after busy rises; q1 sequence 3,4,0,1,...; PW[1] low until q1 wraps to 0.
REQ-037 One-shot, N0=6, NTclk=0 -> busy high exactly 6 cycles, one DONE cycle, then IDLE; all PW=0 afterwards.
REQ-038 MT2=0, MT3=15 with N3=8, N1=0 -> PW[2] never high, PW[3] always high in RUN, PW[1] and TC[1] never high.
REQ-039 st and stop together in IDLE -> stays IDLE; rst=0 during RUN -> next cycle all outputs 0.
REQ-040 With SHADOW_EN, change MT0 3->7 mid-period -> PW[0] width changes only after the next TC[0]; without SHADOW_EN -> change visible next cycle.
